// File: rtl/training_sequencer.sv
// training_sequencer: sequences supervised training of the DNN core.
//
// Runs block cycles of cpc clocks. Slots 2..cpc-1 of each block feed one output
// neuron each; the serial match stream is AND-reduced over those slots to score
// the training case. At each block boundary the case index, epoch, completed-case
// count, total-correct count and rolling accuracy window are stepped. Raises done
// after training_cases*epochs cases.
//
// Ports:
//   clk           clock, all state on rising edge
//   reset         asynchronous active-low reset
//   start         pulse; starts a fresh run from IDLE or DONE
//   pause         level; stop at the next block boundary while high
//   match_in      1 = output neuron (cycle_index-2) matches its ideal bit
//   busy          high in RUN
//   done          high in DONE
//   cycle_index   position within the block cycle
//   cycle_clk     one-clock pulse at the last slot of a block in RUN
//   sel_network   network feed select, cycle_index-2 truncated (0 outside RUN)
//   sel_tc        current training case
//   epoch         completed epochs
//   num_train     completed cases
//   case_valid    one-clock pulse when case_correct is updated
//   case_correct  result of the last completed case
//   recent        correct cases among the last checklast completed cases
//   total_correct cumulative correct cases
module training_sequencer #(
   parameter int unsigned cpc            = 18,
   parameter int unsigned training_cases = 10000,
   parameter int unsigned epochs         = 10,
   parameter int unsigned checklast      = 1000,
   localparam int CW   = $clog2(cpc),
   localparam int SelW = (cpc > 3) ? $clog2(cpc - 2) : 1,
   localparam int TcW  = (training_cases > 1) ? $clog2(training_cases) : 1,
   localparam int RecW = $clog2(checklast + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            pause,
   input  logic            match_in,
   output logic            busy,
   output logic            done,
   output logic [CW-1:0]   cycle_index,
   output logic            cycle_clk,
   output logic [SelW-1:0] sel_network,
   output logic [TcW-1:0]  sel_tc,
   output logic [15:0]     epoch,
   output logic [31:0]     num_train,
   output logic            case_valid,
   output logic            case_correct,
   output logic [RecW-1:0] recent,
   output logic [31:0]     total_correct
);

   localparam int PtrW = (checklast > 1) ? $clog2(checklast) : 1;

   localparam logic [CW-1:0]   CycLast    = CW'(cpc - 1);
   localparam logic [TcW-1:0]  TcLast     = TcW'(training_cases - 1);
   localparam logic [PtrW-1:0] PtrLast    = PtrW'(checklast - 1);
   localparam logic [31:0]     TotalCases = 32'(training_cases * epochs);

   typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cycle_q, cycle_d;
   logic              acc_q, acc_d;
   logic              case_valid_q, case_valid_d;
   logic              case_correct_q, case_correct_d;
   logic [TcW-1:0]    sel_tc_q, sel_tc_d;
   logic [15:0]       epoch_q, epoch_d;
   logic [31:0]       num_train_q, num_train_d;
   logic [31:0]       total_q, total_d;
   logic [RecW-1:0]   recent_q, recent_d;
   logic [checklast-1:0] win_q, win_d;
   logic [PtrW-1:0]   ptr_q, ptr_d;

   // Zero-extended copies of single-bit results for the counter arithmetic
   logic [RecW-1:0]   new_rec, old_rec;
   logic [31:0]       new_tot;

   always_comb begin
      state_d        = state_q;
      cycle_d        = cycle_q;
      acc_d          = acc_q;
      case_valid_d   = 1'b0;
      case_correct_d = case_correct_q;
      sel_tc_d       = sel_tc_q;
      epoch_d        = epoch_q;
      num_train_d    = num_train_q;
      total_d        = total_q;
      recent_d       = recent_q;
      win_d          = win_q;
      ptr_d          = ptr_q;
      new_rec        = '0;
      old_rec        = '0;
      new_tot        = '0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d     = StRun;
               cycle_d     = '0;
               sel_tc_d    = '0;
               epoch_d     = '0;
               num_train_d = '0;
               total_d     = '0;
               recent_d    = '0;
               win_d       = '0;
               ptr_d       = '0;
            end
         end

         StRun: begin
            // Slots 0-1 carry no neuron; the AND chain restarts there
            if (cycle_q < CW'(2)) begin
               acc_d = 1'b1;
            end else begin
               acc_d = acc_q & match_in;
            end

            if (cycle_q == CycLast) begin
               cycle_d        = '0;
               case_correct_d = acc_d;
               case_valid_d   = 1'b1;
               num_train_d    = num_train_q + 32'd1;

               new_tot[0]     = acc_d;
               total_d        = total_q + new_tot;

               new_rec[0]     = acc_d;
               old_rec[0]     = win_q[ptr_q];
               recent_d       = recent_q - old_rec + new_rec;
               win_d[ptr_q]   = acc_d;
               ptr_d          = (ptr_q == PtrLast) ? '0 : ptr_q + PtrW'(1);

               if (sel_tc_q == TcLast) begin
                  sel_tc_d = '0;
                  epoch_d  = epoch_q + 16'd1;
               end else begin
                  sel_tc_d = sel_tc_q + TcW'(1);
               end

               if (num_train_q + 32'd1 == TotalCases) begin
                  state_d = StDone;
               end else if (pause) begin
                  state_d = StPause;
               end
            end else begin
               cycle_d = cycle_q + CW'(1);
            end
         end

         StPause: begin
            if (!pause) begin
               state_d = StRun;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         cycle_q        <= '0;
         acc_q          <= 1'b0;
         case_valid_q   <= 1'b0;
         case_correct_q <= 1'b0;
         sel_tc_q       <= '0;
         epoch_q        <= '0;
         num_train_q    <= '0;
         total_q        <= '0;
         recent_q       <= '0;
         win_q          <= '0;
         ptr_q          <= '0;
      end else begin
         state_q        <= state_d;
         cycle_q        <= cycle_d;
         acc_q          <= acc_d;
         case_valid_q   <= case_valid_d;
         case_correct_q <= case_correct_d;
         sel_tc_q       <= sel_tc_d;
         epoch_q        <= epoch_d;
         num_train_q    <= num_train_d;
         total_q        <= total_d;
         recent_q       <= recent_d;
         win_q          <= win_d;
         ptr_q          <= ptr_d;
      end
   end

   always_comb begin
      busy          = (state_q == StRun);
      done          = (state_q == StDone);
      cycle_index   = cycle_q;
      cycle_clk     = busy && (cycle_q == CycLast);
      // Gated outside RUN so every output reads 0 out of reset
      sel_network   = busy ? SelW'(cycle_q - CW'(2)) : '0;
      sel_tc        = sel_tc_q;
      epoch         = epoch_q;
      num_train     = num_train_q;
      case_valid    = case_valid_q;
      case_correct  = case_correct_q;
      recent        = recent_q;
      total_correct = total_q;
   end

endmodule

// File: tb/tb_training_sequencer.sv
module tb_training_sequencer;

   localparam int CPC = 6;
   localparam int TC  = 3;
   localparam int EP  = 2;
   localparam int CL  = 4;
   localparam int NC  = TC * EP;
   localparam int NK  = NC * CPC;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        match_in = 1'b1;
   logic        busy, done, cycle_clk, case_valid, case_correct;
   logic [2:0]  cycle_index;
   logic [1:0]  sel_network;
   logic [1:0]  sel_tc;
   logic [15:0] epoch;
   logic [31:0] num_train, total_correct;
   logic [2:0]  recent;

   int tests = 0;
   int fails = 0;

   training_sequencer #(
      .cpc(CPC), .training_cases(TC), .epochs(EP), .checklast(CL)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .match_in(match_in),
      .busy(busy), .done(done), .cycle_index(cycle_index), .cycle_clk(cycle_clk),
      .sel_network(sel_network), .sel_tc(sel_tc), .epoch(epoch), .num_train(num_train),
      .case_valid(case_valid), .case_correct(case_correct), .recent(recent),
      .total_correct(total_correct)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NK-1:0]     zm;    // bit k set: match_in=0 at run cycle k
      logic [NC-1:0]     res;   // expected per-case result
      logic [NC-1:0][2:0] rec;  // expected recent after each case
      int                total;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [NC-1:0][2:0] mk_rec(input int a, b, c, d, e, f);
      logic [NC-1:0][2:0] r;
      r[0] = 3'(a); r[1] = 3'(b); r[2] = 3'(c);
      r[3] = 3'(d); r[4] = 3'(e); r[5] = 3'(f);
      return r;
   endfunction

   // Full run from IDLE or DONE, driving match_in from zm and checking every cycle
   task automatic run_check(input string nm, input logic [NK-1:0] zm,
                            input logic [NC-1:0] res, input logic [NC-1:0][2:0] rec,
                            input int total);
      int sum;
      int p;
      int c;
      sum = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({nm, " entry busy"}, 32'(busy), 32'd1);
      chk({nm, " entry num_train"}, num_train, 32'd0);
      chk({nm, " entry total"}, total_correct, 32'd0);
      chk({nm, " entry recent"}, 32'(recent), 32'd0);
      chk({nm, " entry sel_tc"}, 32'(sel_tc), 32'd0);
      chk({nm, " entry epoch"}, 32'(epoch), 32'd0);
      for (int k = 0; k < NK; k++) begin
         p = k % CPC;
         c = k / CPC;
         chk({nm, " cycle_index"}, 32'(cycle_index), 32'(p));
         chk({nm, " cycle_clk"}, 32'(cycle_clk), 32'(p == CPC - 1));
         chk({nm, " sel_network"}, 32'(sel_network), 32'((p + 2) % 4));
         match_in = ~zm[k];
         tick();
         if (p == CPC - 1) begin
            sum += int'(res[c]);
            chk({nm, " case_valid"}, 32'(case_valid), 32'd1);
            chk({nm, " case_correct"}, 32'(case_correct), 32'(res[c]));
            chk({nm, " num_train"}, num_train, 32'(c + 1));
            chk({nm, " total_correct"}, total_correct, 32'(sum));
            chk({nm, " recent"}, 32'(recent), 32'(rec[c]));
            chk({nm, " sel_tc"}, 32'(sel_tc), 32'((c + 1) % TC));
            chk({nm, " epoch"}, 32'(epoch), 32'((c + 1) / TC));
         end else begin
            chk({nm, " case_valid idle"}, 32'(case_valid), 32'd0);
         end
      end
      match_in = 1'b1;
      chk({nm, " done"}, 32'(done), 32'd1);
      chk({nm, " done busy"}, 32'(busy), 32'd0);
      chk({nm, " done cycle_index"}, 32'(cycle_index), 32'd0);
      chk({nm, " final total"}, total_correct, 32'(total));
      tick();
      tick();
      chk({nm, " held num_train"}, num_train, 32'(NC));
      chk({nm, " held total"}, total_correct, 32'(total));
      chk({nm, " held done"}, 32'(done), 32'd1);
   endtask

   initial begin
      logic [NK-1:0]      zm;
      logic [NC-1:0]      res;
      logic [NC-1:0][2:0] rec;
      int                 tot;
      int                 s;

      // Directed vectors
      vecs[0].zm = '0;
      vecs[0].res = '1;
      vecs[0].rec = mk_rec(1, 2, 3, 4, 4, 4);
      vecs[0].total = 6;

      vecs[1].zm = '0;
      vecs[1].zm[1*CPC + 4] = 1'b1;
      vecs[1].res = 6'b111101;
      vecs[1].rec = mk_rec(1, 1, 2, 3, 3, 4);
      vecs[1].total = 5;

      vecs[2].zm = '0;
      for (int c = 0; c < NC; c++) begin
         vecs[2].zm[c*CPC]     = 1'b1;
         vecs[2].zm[c*CPC + 1] = 1'b1;
      end
      vecs[2].res = '1;
      vecs[2].rec = mk_rec(1, 2, 3, 4, 4, 4);
      vecs[2].total = 6;

      vecs[3].zm = '0;
      vecs[3].zm[2*CPC + 2] = 1'b1;
      vecs[3].zm[5*CPC + 5] = 1'b1;
      vecs[3].res = 6'b011011;
      vecs[3].rec = mk_rec(1, 2, 2, 3, 3, 2);
      vecs[3].total = 4;

      // Reset state
      #12;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst cycle_index", 32'(cycle_index), 32'd0);
      chk("rst cycle_clk", 32'(cycle_clk), 32'd0);
      chk("rst sel_network", 32'(sel_network), 32'd0);
      chk("rst num_train", num_train, 32'd0);
      chk("rst recent", 32'(recent), 32'd0);
      chk("rst case_valid", 32'(case_valid), 32'd0);
      reset = 1'b1;
      tick();
      tick();
      chk("idle cycle_index", 32'(cycle_index), 32'd0);

      for (int i = 0; i < 4; i++) begin
         run_check($sformatf("vec%0d", i), vecs[i].zm, vecs[i].res, vecs[i].rec,
                   vecs[i].total);
      end

      // Randomised runs against a case-level model
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < NK; k++) zm[k] = ($urandom_range(0, 9) == 0);
         tot = 0;
         for (int c = 0; c < NC; c++) begin
            res[c] = 1'b1;
            for (int p = 2; p < CPC; p++) if (zm[c*CPC + p]) res[c] = 1'b0;
            tot += int'(res[c]);
            s = 0;
            for (int j = c - CL + 1; j <= c; j++) if (j >= 0) s += int'(res[j]);
            rec[c] = 3'(s);
         end
         run_check($sformatf("rand%0d", r), zm, res, rec, tot);
      end

      // Pause at cycle 3 of case 1
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("pause pre ci", 32'(cycle_index), 32'd3);
      pause = 1'b1;
      tick();
      chk("pause midblock ci", 32'(cycle_index), 32'd4);
      chk("pause midblock busy", 32'(busy), 32'd1);
      tick();
      tick();
      chk("pause entry busy", 32'(busy), 32'd0);
      chk("pause entry done", 32'(done), 32'd0);
      chk("pause entry ci", 32'(cycle_index), 32'd0);
      chk("pause entry sel_tc", 32'(sel_tc), 32'd1);
      chk("pause entry num_train", num_train, 32'd1);
      chk("pause entry case_valid", 32'(case_valid), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("pause start ignored busy", 32'(busy), 32'd0);
      chk("pause case_valid drop", 32'(case_valid), 32'd0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("pause frozen num_train", num_train, 32'd1);
      end
      chk("pause frozen sel_tc", 32'(sel_tc), 32'd1);
      chk("pause frozen ci", 32'(cycle_index), 32'd0);
      pause = 1'b0;
      tick();
      chk("resume busy", 32'(busy), 32'd1);
      chk("resume ci", 32'(cycle_index), 32'd0);
      for (int i = 0; i < CPC - 1; i++) tick();
      chk("resume ci last", 32'(cycle_index), 32'(CPC - 1));
      tick();
      chk("resume case_valid", 32'(case_valid), 32'd1);
      chk("resume num_train", num_train, 32'd2);
      chk("resume sel_tc", 32'(sel_tc), 32'd2);
      begin
         int budget;
         budget = 0;
         while (!done && budget < 100) begin
            tick();
            budget++;
         end
      end
      chk("pause run done", 32'(done), 32'd1);
      chk("pause run num_train", num_train, 32'd6);
      chk("pause run total", total_correct, 32'd6);

      // Reset at cycle 3 of case 2, with an ignored start mid-block
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("run start ignored ci", 32'(cycle_index), 32'd2);
      chk("run start ignored num_train", num_train, 32'd0);
      for (int i = 0; i < 7; i++) tick();
      chk("rst2 pre ci", 32'(cycle_index), 32'd3);
      chk("rst2 pre sel_tc", 32'(sel_tc), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rst2 busy", 32'(busy), 32'd0);
      chk("rst2 ci", 32'(cycle_index), 32'd0);
      chk("rst2 sel_tc", 32'(sel_tc), 32'd0);
      chk("rst2 num_train", num_train, 32'd0);
      chk("rst2 total", total_correct, 32'd0);
      chk("rst2 recent", 32'(recent), 32'd0);
      chk("rst2 case_correct", 32'(case_correct), 32'd0);
      #1;
      reset = 1'b1;
      tick();
      chk("rst2 idle busy", 32'(busy), 32'd0);
      chk("rst2 idle ci", 32'(cycle_index), 32'd0);
      run_check("after_reset", vecs[1].zm, vecs[1].res, vecs[1].rec, vecs[1].total);
      run_check("restart_done", vecs[0].zm, vecs[0].res, vecs[0].rec, vecs[0].total);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
